// File: rtl/emulib_rammodel_encoder_a_pkg.sv
// Shared definitions for the RAM-model A-channel encoder.
// W0 field layout is the one the A-channel decoder unpacks.
package emulib_rammodel_encoder_a_pkg;

   localparam int ID_HI     = 31;
   localparam int ID_LO     = 16;
   localparam int LEN_HI    = 15;
   localparam int LEN_LO    = 8;
   localparam int SIZE_HI   = 7;
   localparam int SIZE_LO   = 5;
   localparam int BURST_HI  = 4;
   localparam int BURST_LO  = 3;
   localparam int WRITE_BIT = 0;

   typedef enum logic [1:0] {
      S_W0 = 2'd0,
      S_W1 = 2'd1,
      S_W2 = 2'd2
   } ser_state_t;

   // Packets carry two words for narrow addresses, three otherwise.
   function automatic bit addr_32(input int aw);
      return aw <= 32;
   endfunction

   function automatic logic [31:0] pack_w0(
      input logic [15:0] id,
      input logic [7:0]  len,
      input logic [2:0]  size,
      input logic [1:0]  burst,
      input logic        write
   );
      logic [31:0] w;
      w                      = '0;
      w[ID_HI:ID_LO]         = id;
      w[LEN_HI:LEN_LO]       = len;
      w[SIZE_HI:SIZE_LO]     = size;
      w[BURST_HI:BURST_LO]   = burst;
      w[WRITE_BIT]           = write;
      return w;
   endfunction

endpackage

// File: rtl/emulib_rammodel_a_queue.sv
// Small synchronous FIFO holding pending A-channel requests.
// Active-low synchronous reset clears pointers and count only.
module emulib_rammodel_a_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A full queue never accepts, even when the head leaves this cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= inc(wr_ptr);
         if (do_pop)  rd_ptr <= inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/emulib_rammodel_encoder_a.sv
// Serializes A-channel requests into 32-bit words for the RAM model.
// A request queue lets new requests land while a packet streams out.
module emulib_rammodel_encoder_a
   import emulib_rammodel_encoder_a_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 64,
   parameter int ID_WIDTH    = 4,
   parameter int QUEUE_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  axi_avalid,
   output logic                  axi_aready,
   input  logic                  axi_awrite,
   input  logic [ADDR_WIDTH-1:0] axi_aaddr,
   input  logic [ID_WIDTH-1:0]   axi_aid,
   input  logic [7:0]            axi_alen,
   input  logic [2:0]            axi_asize,
   input  logic [1:0]            axi_aburst,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic [31:0]           data,
   output logic                  idle
);

   localparam bit ADDR_WIDE = !addr_32(ADDR_WIDTH);
   localparam int QW = 1 + ADDR_WIDTH + ID_WIDTH + 8 + 3 + 2;

   if (ID_WIDTH > 16 || ADDR_WIDTH > 64 || DATA_WIDTH % 8 != 0
       || QUEUE_DEPTH < 1) begin : g_param_check
      $error("emulib_rammodel_encoder_a: unsupported parameters");
   end

   logic [QW-1:0]         q_in;
   logic [QW-1:0]         q_out;
   logic                  q_full;
   logic                  q_empty;
   logic                  q_pop;

   logic                  h_write;
   logic [ADDR_WIDTH-1:0] h_addr;
   logic [ID_WIDTH-1:0]   h_id;
   logic [7:0]            h_len;
   logic [2:0]            h_size;
   logic [1:0]            h_burst;
   logic [63:0]           addr64;

   ser_state_t            state;
   ser_state_t            state_n;
   logic                  data_fire;
   logic                  last_word;
   logic [31:0]           word;

   assign q_in = {axi_awrite, axi_aaddr, axi_aid,
                  axi_alen, axi_asize, axi_aburst};

   emulib_rammodel_a_queue #(
      .WIDTH (QW),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk   (clk),
      .rstn  (rstn),
      .push  (axi_avalid),
      .wdata (q_in),
      .pop   (q_pop),
      .rdata (q_out),
      .full  (q_full),
      .empty (q_empty)
   );

   assign {h_write, h_addr, h_id, h_len, h_size, h_burst} = q_out;
   assign addr64 = 64'(h_addr);

   assign axi_aready = !q_full;
   assign data_valid = !q_empty;
   assign data_fire  = data_valid && data_ready;
   assign data       = word;
   assign idle       = q_empty && (state == S_W0);

   // The head stays queued until its final word leaves.
   assign q_pop = data_fire && last_word;

   always_ff @(posedge clk) begin
      if (!rstn) state <= S_W0;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      word      = '0;
      last_word = 1'b0;
      case (state)
         S_W0: begin
            word = pack_w0(16'(h_id), h_len, h_size, h_burst, h_write);
            if (data_fire) state_n = S_W1;
         end
         S_W1: begin
            word      = addr64[31:0];
            last_word = !ADDR_WIDE;
            if (data_fire) state_n = ADDR_WIDE ? S_W2 : S_W0;
         end
         S_W2: begin
            word      = addr64[63:32];
            last_word = 1'b1;
            if (data_fire) state_n = S_W0;
         end
         default: state_n = S_W0;
      endcase
   end

endmodule

// File: tb/tb_emulib_rammodel_encoder_a.sv
// Directed bench for the A-channel encoder, 32- and 64-bit address builds.
// Table vectors plus sequences for backpressure, full queue and reset.
module tb_emulib_rammodel_encoder_a;

   logic        clk;
   logic        rstn;
   logic        req_write;
   logic [63:0] req_addr;
   logic [3:0]  req_id;
   logic [7:0]  req_len;
   logic [2:0]  req_size;
   logic [1:0]  req_burst;

   logic        av32, ar32, dv32, dr32, idle32;
   logic [31:0] data32;
   logic        av64, ar64, dv64, dr64, idle64;
   logic [31:0] data64;

   int nvec;
   int nerr;

   typedef struct {
      logic        write;
      logic [3:0]  id;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [31:0] addr;
      logic [31:0] w0;
   } vec_t;

   vec_t tab [4];

   emulib_rammodel_encoder_a #(
      .ADDR_WIDTH (32), .DATA_WIDTH (64),
      .ID_WIDTH (4), .QUEUE_DEPTH (2)
   ) u32 (
      .clk (clk), .rstn (rstn),
      .axi_avalid (av32), .axi_aready (ar32),
      .axi_awrite (req_write), .axi_aaddr (req_addr[31:0]),
      .axi_aid (req_id), .axi_alen (req_len),
      .axi_asize (req_size), .axi_aburst (req_burst),
      .data_valid (dv32), .data_ready (dr32),
      .data (data32), .idle (idle32)
   );

   emulib_rammodel_encoder_a #(
      .ADDR_WIDTH (64), .DATA_WIDTH (64),
      .ID_WIDTH (4), .QUEUE_DEPTH (2)
   ) u64 (
      .clk (clk), .rstn (rstn),
      .axi_avalid (av64), .axi_aready (ar64),
      .axi_awrite (req_write), .axi_aaddr (req_addr),
      .axi_aid (req_id), .axi_alen (req_len),
      .axi_asize (req_size), .axi_aburst (req_burst),
      .data_valid (dv64), .data_ready (dr64),
      .data (data64), .idle (idle64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input vec_t v);
      req_write = v.write;
      req_id    = v.id;
      req_len   = v.len;
      req_size  = v.size;
      req_burst = v.burst;
      req_addr  = {32'h0, v.addr};
   endtask

   // Called at a negedge; returns at the negedge after the accept.
   task automatic send(input bit s);
      bit ok;
      ok = 1'b0;
      if (s) av64 = 1'b1;
      else   av32 = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = s ? ar64 : ar32;
         @(negedge clk);
      end
      av32 = 1'b0;
      av64 = 1'b0;
      check("send_accept", 64'(ok), 64'd1);
   endtask

   // Takes one word with data_ready high; returns after its fire.
   task automatic get_word(input bit s, output logic [31:0] w);
      bit got;
      got = 1'b0;
      w   = 'x;
      if (s) dr64 = 1'b1;
      else   dr32 = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         if (s ? dv64 : dv32) begin
            w   = s ? data64 : data32;
            got = 1'b1;
         end
         @(negedge clk);
      end
      if (!got) check("word_timeout", 64'(got), 64'd1);
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] words [$];
      int          cpos;
      bit          csent;
      int          idx;
      int          first;
      int          last;
      vec_t        va, vb, vc;

      nvec = 0;
      nerr = 0;
      tab[0] = '{1'b1, 4'h5, 8'h0F, 3'd3, 2'd1, 32'h8000_1000, 32'h0005_0F69};
      tab[1] = '{1'b0, 4'hF, 8'h00, 3'd0, 2'd0, 32'h0000_0004, 32'h000F_0000};
      tab[2] = '{1'b1, 4'hA, 8'hFF, 3'd7, 2'd2, 32'hFFFF_FFFC, 32'h000A_FFF1};
      tab[3] = '{1'b0, 4'h0, 8'h01, 3'd2, 2'd3, 32'h1234_5678, 32'h0000_0158};

      rstn = 1'b0;
      av32 = 1'b0; dr32 = 1'b0;
      av64 = 1'b0; dr64 = 1'b0;
      set_req(tab[0]);
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      check("rst_dvalid", 64'(dv32), 64'd0);
      check("rst_aready", 64'(ar32), 64'd1);
      check("rst_idle", 64'(idle32), 64'd1);
      check("rst_dvalid64", 64'(dv64), 64'd0);

      for (int i = 0; i < 4; i++) begin
         set_req(tab[i]);
         dr32 = 1'b1;
         send(1'b0);
         if (i == 0) check("latency_dvalid", 64'(dv32), 64'd1);
         get_word(1'b0, w);
         check($sformatf("tab%0d_w0", i), 64'(w), 64'(tab[i].w0));
         get_word(1'b0, w);
         check($sformatf("tab%0d_w1", i), 64'(w), 64'(tab[i].addr));
         check($sformatf("tab%0d_idle", i), 64'(idle32), 64'd1);
      end

      req_write = 1'b0; req_id = 4'h2; req_len = 8'h00;
      req_size  = 3'd0; req_burst = 2'd0;
      req_addr  = 64'h0000_0001_2345_6780;
      send(1'b1);
      get_word(1'b1, w);
      check("a64_w0", 64'(w), 64'h0002_0000);
      check("a64_w0_write", 64'(w[0]), 64'd0);
      get_word(1'b1, w);
      check("a64_w1", 64'(w), 64'h2345_6780);
      get_word(1'b1, w);
      check("a64_w2", 64'(w), 64'h0000_0001);
      check("a64_idle", 64'(idle64), 64'd1);

      req_write = 1'b1; req_id = 4'h3; req_len = 8'h07;
      req_size  = 3'd2; req_burst = 2'd1;
      req_addr  = 64'h0000_00AB_CDEF_0000;
      send(1'b1);
      get_word(1'b1, w);
      check("bp_w0", 64'(w), 64'h0003_0749);
      dr64 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", 64'(dv64), 64'd1);
         check("bp_hold_data", 64'(data64), 64'hCDEF_0000);
         @(negedge clk);
      end
      get_word(1'b1, w);
      check("bp_w1", 64'(w), 64'hCDEF_0000);
      get_word(1'b1, w);
      check("bp_w2", 64'(w), 64'h0000_00AB);
      check("bp_idle", 64'(idle64), 64'd1);

      va = '{1'b1, 4'h1, 8'h00, 3'd0, 2'd0, 32'h0000_0100, 32'h0001_0001};
      vb = '{1'b0, 4'h2, 8'h03, 3'd1, 2'd1, 32'h0000_0200, 32'h0002_0328};
      vc = '{1'b1, 4'h3, 8'h00, 3'd2, 2'd2, 32'h0000_0300, 32'h0003_0051};
      dr32 = 1'b0;
      set_req(va);
      send(1'b0);
      set_req(vb);
      send(1'b0);
      set_req(vc);
      av32 = 1'b1;
      check("full_aready", 64'(ar32), 64'd0);
      @(negedge clk);
      check("full_aready_hold", 64'(ar32), 64'd0);
      check("full_head_w0", 64'(data32), 64'(va.w0));
      dr32  = 1'b1;
      csent = 1'b0;
      cpos  = -1;
      words.delete();
      for (int c = 0; c < 40 && words.size() < 6; c++) begin
         if (csent) av32 = 1'b0;
         if (av32 && ar32) begin
            csent = 1'b1;
            cpos  = words.size();
         end
         if (dv32) words.push_back(data32);
         @(negedge clk);
      end
      av32 = 1'b0;
      check("full_accept_pos", 64'(cpos), 64'd2);
      check("full_nwords", 64'(words.size()), 64'd6);
      if (words.size() == 6) begin
         check("full_a_w0", 64'(words[0]), 64'(va.w0));
         check("full_a_w1", 64'(words[1]), 64'(va.addr));
         check("full_b_w0", 64'(words[2]), 64'(vb.w0));
         check("full_b_w1", 64'(words[3]), 64'(vb.addr));
         check("full_c_w0", 64'(words[4]), 64'(vc.w0));
         check("full_c_w1", 64'(words[5]), 64'(vc.addr));
      end

      idx   = 0;
      first = -1;
      last  = -1;
      words.delete();
      dr32  = 1'b1;
      for (int c = 0; c < 60 && words.size() < 8; c++) begin
         if (idx < 4) begin
            av32 = 1'b1;
            set_req(tab[idx]);
         end else begin
            av32 = 1'b0;
         end
         if (av32 && ar32) idx++;
         if (dv32) begin
            if (first < 0) first = c;
            last = c;
            words.push_back(data32);
         end
         @(negedge clk);
      end
      av32 = 1'b0;
      check("b2b_nwords", 64'(words.size()), 64'd8);
      check("b2b_span", 64'(last - first), 64'd7);
      if (words.size() == 8) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b%0d_w0", k), 64'(words[2*k]),
                  64'(tab[k].w0));
            check($sformatf("b2b%0d_w1", k), 64'(words[2*k+1]),
                  64'(tab[k].addr));
         end
      end
      check("b2b_idle", 64'(idle32), 64'd1);

      set_req(tab[0]);
      send(1'b0);
      get_word(1'b0, w);
      check("rstmid_w0", 64'(w), 64'(tab[0].w0));
      dr32 = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check("rstmid_dvalid", 64'(dv32), 64'd0);
      check("rstmid_aready", 64'(ar32), 64'd1);
      check("rstmid_idle", 64'(idle32), 64'd1);
      dr32 = 1'b1;
      @(negedge clk);
      check("rstmid_no_cont", 64'(dv32), 64'd0);
      set_req(tab[1]);
      send(1'b0);
      get_word(1'b0, w);
      check("rstmid_new_w0", 64'(w), 64'(tab[1].w0));
      get_word(1'b0, w);
      check("rstmid_new_w1", 64'(w), 64'(tab[1].addr));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
